// File: rtl/nfu2_accum_pipe.sv
// Purpose: NFU-2 stage, per-lane adder-tree reduction of Tn signed products and multi-beat accumulation (wrap or saturate).
// Latency: last beat accepted at edge t, result presented with o_valid from edge t+2.
// Backpressure: o_ready low in FLUSH/DONE; result held in DONE until i_ready, beats are not accepted meanwhile.
module nfu2_accum_pipe #(
  parameter int BIT_WIDTH = 16,
  parameter int Tn        = 16,
  parameter int NUM_LANES = 4,
  parameter int PASS_W    = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic [NUM_LANES*Tn*BIT_WIDTH-1:0] i_nfu1,
  input  logic [NUM_LANES*BIT_WIDTH-1:0]    i_partial_sum,
  input  logic                              i_load_partial_sum,
  input  logic [PASS_W-1:0]                 i_num_passes,
  input  logic                              i_sat_en,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [NUM_LANES*BIT_WIDTH-1:0]    o_output,
  output logic                              o_busy
);

  localparam int LOG_TN = $clog2(Tn);
  localparam int TW     = BIT_WIDTH + LOG_TN;  // full-precision tree width
  localparam int SW     = TW + 1;              // accumulator + tree without overflow
  localparam logic signed [SW-1:0] MAXV = {{(SW-BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-BIT_WIDTH+1){1'b1}}, {(BIT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;

  state_t                              state;
  logic [PASS_W-1:0]                   passes;
  logic [PASS_W-1:0]                   beat_cnt;
  logic                                sat_q;
  logic                                load_q;
  logic [NUM_LANES*BIT_WIDTH-1:0]      ps_q;
  logic [NUM_LANES*Tn*BIT_WIDTH-1:0]   s1_prod;
  logic                                s1_vld;
  logic                                s1_first;
  logic                                s1_last;
  logic [NUM_LANES*BIT_WIDTH-1:0]      acc;
  logic [NUM_LANES*BIT_WIDTH-1:0]      acc_nxt;

  logic                                accept;
  logic [PASS_W-1:0]                   cur_passes;
  logic [PASS_W-1:0]                   cur_cnt;
  logic                                is_last;
  logic signed [TW-1:0]                tree;
  logic signed [BIT_WIDTH-1:0]         base;
  logic signed [SW-1:0]                sum;

  assign o_ready  = (state == IDLE) || (state == ACCUM);
  assign o_busy   = (state != IDLE);
  assign o_valid  = (state == DONE);
  assign o_output = o_valid ? acc : '0;
  assign accept   = i_valid && o_ready;

  // In IDLE the incoming beat is the first one, so last-beat detection uses the live pass count.
  always_comb begin
    cur_passes = passes;
    cur_cnt    = beat_cnt;
    if (state == IDLE) begin
      cur_passes = (i_num_passes == '0) ? PASS_W'(1) : i_num_passes;
      cur_cnt    = '0;
    end
    is_last = (cur_cnt == cur_passes - PASS_W'(1));
  end

  // Control FSM: pass configuration latch, beat counting and result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      passes   <= '0;
      beat_cnt <= '0;
      sat_q    <= 1'b0;
      load_q   <= 1'b0;
      ps_q     <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          passes   <= cur_passes;
          sat_q    <= i_sat_en;
          load_q   <= i_load_partial_sum;
          ps_q     <= i_partial_sum;
          beat_cnt <= PASS_W'(1);
          state    <= is_last ? FLUSH : ACCUM;
        end
        ACCUM: if (accept) begin
          beat_cnt <= beat_cnt + PASS_W'(1);
          if (is_last) state <= FLUSH;
        end
        // Leave once the last beat has left S1 and landed in the accumulator.
        FLUSH: if (!(s1_vld && s1_last)) state <= DONE;
        DONE: if (i_ready) begin
          beat_cnt <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Input stage S1: registers products and beat-position flags so the tree never sees i_nfu1 directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_prod  <= i_nfu1;
        s1_first <= (state == IDLE);
        s1_last  <= is_last;
      end
    end
  end

  // Per-lane adder tree at full precision, then add to seed/accumulator and wrap or clamp.
  always_comb begin
    acc_nxt = '0;
    tree    = '0;
    base    = '0;
    sum     = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      tree = '0;
      for (int k = 0; k < Tn; k++) begin
        tree = tree + TW'($signed(s1_prod[(l*Tn+k)*BIT_WIDTH +: BIT_WIDTH]));
      end
      if (!s1_first)   base = acc[l*BIT_WIDTH +: BIT_WIDTH];
      else if (load_q) base = ps_q[l*BIT_WIDTH +: BIT_WIDTH];
      else             base = '0;
      sum = SW'(base) + SW'(tree);
      if (sat_q && (sum > MAXV))      acc_nxt[l*BIT_WIDTH +: BIT_WIDTH] = MAXV[BIT_WIDTH-1:0];
      else if (sat_q && (sum < MINV)) acc_nxt[l*BIT_WIDTH +: BIT_WIDTH] = MINV[BIT_WIDTH-1:0];
      else                            acc_nxt[l*BIT_WIDTH +: BIT_WIDTH] = sum[BIT_WIDTH-1:0];
    end
  end

  // Accumulator register: advances only when S1 holds a beat, so gaps leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= '0;
    else if (s1_vld) acc <= acc_nxt;
  end

endmodule

// File: tb/tb_nfu2_accum_pipe.sv
module tb_nfu2_accum_pipe;
  localparam int BW = 16;
  localparam int TN = 16;
  localparam int NL = 4;
  localparam int PW = 8;
  localparam int VW = NL*TN*BW;
  localparam int OW = NL*BW;

  logic          clk;
  logic          rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [VW-1:0] i_nfu1;
  logic [OW-1:0] i_partial_sum;
  logic          i_load_partial_sum;
  logic [PW-1:0] i_num_passes;
  logic          i_sat_en;
  logic          o_valid;
  logic          i_ready;
  logic [OW-1:0] o_output;
  logic          o_busy;

  nfu2_accum_pipe #(.BIT_WIDTH(BW), .Tn(TN), .NUM_LANES(NL), .PASS_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_nfu1(i_nfu1),
    .i_partial_sum(i_partial_sum), .i_load_partial_sum(i_load_partial_sum),
    .i_num_passes(i_num_passes), .i_sat_en(i_sat_en), .o_valid(o_valid),
    .i_ready(i_ready), .o_output(o_output), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int passed;
  logic [VW-1:0] beats_q[$];

  function automatic logic [VW-1:0] fill(input logic [BW-1:0] v);
    logic [VW-1:0] r;
    for (int i = 0; i < NL*TN; i++) r[i*BW +: BW] = v;
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < VW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: each lane's result is the seed plus the plain integer sum of all its products,
  // wrapped to BW bits or clamped to the signed range after every beat.
  function automatic logic [OW-1:0] model(input int nb, input logic load, input logic sat,
                                          input logic [OW-1:0] ps);
    logic [OW-1:0]        r;
    longint               a;
    longint               t;
    logic signed [BW-1:0] w;
    longint               maxv;
    longint               minv;
    maxv = (longint'(1) <<< (BW-1)) - 1;
    minv = -(longint'(1) <<< (BW-1));
    r = '0;
    for (int l = 0; l < NL; l++) begin
      a = load ? longint'($signed(ps[l*BW +: BW])) : 0;
      for (int b = 0; b < nb; b++) begin
        t = 0;
        for (int k = 0; k < TN; k++) t += longint'($signed(beats_q[b][(l*TN+k)*BW +: BW]));
        a = a + t;
        if (sat) begin
          if (a > maxv) a = maxv;
          else if (a < minv) a = minv;
        end else begin
          w = a[BW-1:0];
          a = longint'(w);
        end
      end
      r[l*BW +: BW] = a[BW-1:0];
    end
    return r;
  endfunction

  task automatic run_pass(input int np, input logic load, input logic sat, input logic [OW-1:0] ps,
                          input int gap, input int hold, input logic noise,
                          input logic [OW-1:0] exp, input string name);
    int nb;
    nb = (np == 0) ? 1 : np;
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      total++;
      if (o_ready !== 1'b1) $display("FAIL %s_ready beat%0d: o_ready=%b expected 1", name, b, o_ready);
      else passed++;
      i_valid = 1'b1;
      i_nfu1  = beats_q[b];
      if (b == 0) begin
        i_num_passes = PW'(np); i_sat_en = sat; i_load_partial_sum = load; i_partial_sum = ps;
      end else begin
        i_num_passes = PW'($urandom); i_sat_en = $urandom; i_load_partial_sum = $urandom;
        i_partial_sum = {$urandom, $urandom};
      end
      @(posedge clk);
      if (b != nb-1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk); i_valid = 1'b0; i_nfu1 = rand_vec();
          @(posedge clk);
        end
      end
    end
    @(negedge clk);
    i_valid = noise; i_nfu1 = rand_vec();
    total++;
    if (o_valid !== 1'b0 || o_ready !== 1'b0 || o_busy !== 1'b1)
      $display("FAIL %s_flush1: valid=%b ready=%b busy=%b expected 0/0/1", name, o_valid, o_ready, o_busy);
    else passed++;
    @(negedge clk);
    total++;
    if (o_valid !== 1'b0 || o_output !== '0)
      $display("FAIL %s_flush2: valid=%b out=%h expected 0/0", name, o_valid, o_output);
    else passed++;
    @(negedge clk);
    total++;
    if (o_valid !== 1'b1 || o_output !== exp)
      $display("FAIL %s_result: valid=%b out=%h expected 1/%h", name, o_valid, o_output, exp);
    else passed++;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      total++;
      if (o_valid !== 1'b1 || o_output !== exp || o_ready !== 1'b0)
        $display("FAIL %s_hold%0d: valid=%b ready=%b out=%h expected 1/0/%h", name, h, o_valid, o_ready, o_output, exp);
      else passed++;
    end
    i_ready = 1'b1; i_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    i_ready = 1'b0;
    total++;
    if (o_valid !== 1'b0 || o_output !== '0 || o_busy !== 1'b0 || o_ready !== 1'b1)
      $display("FAIL %s_release: valid=%b busy=%b ready=%b out=%h expected 0/0/1/0", name, o_valid, o_busy, o_ready, o_output);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_nfu1 = '0; i_partial_sum = '0;
    i_load_partial_sum = 1'b0; i_num_passes = '0; i_sat_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_output !== '0)
      $display("FAIL reset: ready=%b valid=%b busy=%b out=%h expected 1/0/0/0", o_ready, o_valid, o_busy, o_output);
    else passed++;
  endtask

  task automatic test_multi_pass();
    beats_q = {fill(16'h0001), fill(16'h0001), fill(16'h0001)};
    run_pass(3, 1'b0, 1'b0, '0, 0, 0, 1'b0, {4{16'd48}}, "multi_pass");
  endtask

  task automatic test_partial_seed();
    beats_q = {fill(16'h0002)};
    run_pass(1, 1'b1, 1'b0, {16'd7, 16'd0, 16'hFFFB, 16'd100}, 0, 0, 1'b0,
             {16'd39, 16'd32, 16'd27, 16'd132}, "partial_seed");
  endtask

  task automatic test_wrap_sat();
    beats_q = {fill(16'h7FFF)};
    run_pass(1, 1'b0, 1'b0, '0, 0, 0, 1'b0, {4{16'hFFF0}}, "wrap");
    run_pass(1, 1'b0, 1'b1, '0, 0, 0, 1'b0, {4{16'h7FFF}}, "sat_pos");
    beats_q = {fill(16'h8000)};
    run_pass(1, 1'b0, 1'b1, '0, 0, 0, 1'b0, {4{16'h8000}}, "sat_neg");
  endtask

  task automatic test_backpressure();
    beats_q = {fill(16'h0003), fill(16'hFFFE)};
    run_pass(2, 1'b0, 1'b0, '0, 0, 5, 1'b1, {4{16'd16}}, "backpressure");
  endtask

  task automatic test_neg_gaps();
    beats_q = {fill(16'hFFFF), fill(16'hFFFF)};
    run_pass(2, 1'b0, 1'b0, '0, 1, 0, 1'b0, {4{16'hFFE0}}, "neg_gaps");
  endtask

  task automatic test_passes_zero();
    beats_q = {fill(16'h0001)};
    run_pass(0, 1'b0, 1'b0, '0, 0, 0, 1'b0, {4{16'd16}}, "passes_zero");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    i_valid = 1'b1; i_nfu1 = fill(16'h0005); i_num_passes = 8'd4; i_sat_en = 1'b0;
    i_load_partial_sum = 1'b1; i_partial_sum = {4{16'd9}};
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_output !== '0)
      $display("FAIL reset_mid_async: busy=%b valid=%b out=%h expected 0/0/0", o_busy, o_valid, o_output);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0)
      $display("FAIL reset_mid_after: ready=%b busy=%b expected 1/0", o_ready, o_busy);
    else passed++;
    beats_q = {fill(16'h0001)};
    run_pass(1, 1'b0, 1'b0, '0, 0, 0, 1'b0, {4{16'd16}}, "reset_mid_next");
  endtask

  task automatic test_random();
    int np; logic ld; logic st; logic [OW-1:0] ps;
    for (int it = 0; it < 8; it++) begin
      np = $urandom_range(1, 4);
      ld = $urandom; st = $urandom;
      ps = {$urandom, $urandom};
      beats_q = {};
      for (int b = 0; b < np; b++) beats_q.push_back(rand_vec());
      run_pass(np, ld, st, ps, $urandom_range(0, 2), $urandom_range(0, 3), $urandom,
               model(np, ld, st, ps), $sformatf("random%0d", it));
    end
  endtask

  initial begin
    total = 0;
    passed = 0;
    test_reset();
    test_multi_pass();
    test_partial_seed();
    test_wrap_sat();
    test_backpressure();
    test_neg_gaps();
    test_passes_zero();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
